// File: rtl/vga_sync_gen.sv
// 640x480@60 timing generator: free-running counters feed x/y to the renderer, and the
// sync/blank decode is delayed so it lines up with the pixel colour that comes back.
`timescale 1ns/1ps

module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIPE_LAT = 2
) (
  input  logic       vga_clk,
  input  logic       rst_n,
  input  logic [7:0] pixel_color,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       frame_start,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       hs_raw;
  logic       vs_raw;
  logic       vis_raw;
  logic       hs_dly;
  logic       vs_dly;
  logic       vis_dly;

  // Line counter steps only when the pixel counter wraps; both wrap together at frame end.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  assign x           = h_cnt;
  assign y           = v_cnt;
  assign active      = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0);

  assign hs_raw  = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
  assign vs_raw  = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
  assign vis_raw = active;

  // The delay line matches the renderer latency so that sync/blank meet their own pixel.
  generate
    if (PIPE_LAT == 0) begin : g_no_pipe
      assign hs_dly  = hs_raw;
      assign vs_dly  = vs_raw;
      assign vis_dly = vis_raw;
    end else begin : g_pipe
      logic [PIPE_LAT-1:0] hs_pipe;
      logic [PIPE_LAT-1:0] vs_pipe;
      logic [PIPE_LAT-1:0] vis_pipe;

      always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
          hs_pipe  <= '1;
          vs_pipe  <= '1;
          vis_pipe <= '0;
        end else begin
          hs_pipe  <= PIPE_LAT'({hs_pipe, hs_raw});
          vs_pipe  <= PIPE_LAT'({vs_pipe, vs_raw});
          vis_pipe <= PIPE_LAT'({vis_pipe, vis_raw});
        end
      end

      assign hs_dly  = hs_pipe[PIPE_LAT-1];
      assign vs_dly  = vs_pipe[PIPE_LAT-1];
      assign vis_dly = vis_pipe[PIPE_LAT-1];
    end
  endgenerate

  // Bit replication spreads 3/3/2-bit colour across the full 8-bit DAC range.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
    end else begin
      vga_hs      <= hs_dly;
      vga_vs      <= vs_dly;
      vga_blank_n <= vis_dly;
      if (vis_dly) begin
        vga_r <= {pixel_color[7:5], pixel_color[7:5], pixel_color[7:6]};
        vga_g <= {pixel_color[4:2], pixel_color[4:2], pixel_color[4:3]};
        vga_b <= {pixel_color[1:0], pixel_color[1:0], pixel_color[1:0], pixel_color[1:0]};
      end else begin
        vga_r <= '0;
        vga_g <= '0;
        vga_b <= '0;
      end
    end
  end

  assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: one full-size instance plus two shrunken-geometry instances
// (latency 0 and 5) compared every clock against an arithmetic timing model.
`timescale 1ns/1ps

module tb_vga_sync_gen;

  localparam int NDUT = 3;
  localparam int HA  [NDUT] = '{640, 16, 16};
  localparam int HF  [NDUT] = '{16, 2, 2};
  localparam int HS  [NDUT] = '{96, 4, 4};
  localparam int HB  [NDUT] = '{48, 3, 3};
  localparam int VA  [NDUT] = '{480, 6, 6};
  localparam int VF  [NDUT] = '{10, 1, 1};
  localparam int VS  [NDUT] = '{2, 2, 2};
  localparam int VB  [NDUT] = '{33, 2, 2};
  localparam int LAT [NDUT] = '{2, 0, 5};

  typedef enum logic [1:0] {MODE_RANDOM, MODE_CONST, MODE_ALIGN} mode_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pix [NDUT];
  logic [9:0] xo  [NDUT];
  logic [9:0] yo  [NDUT];
  logic [7:0] ro  [NDUT];
  logic [7:0] go  [NDUT];
  logic [7:0] bo  [NDUT];
  logic [NDUT-1:0] act, fs, hs, vs, bl, sn;

  int    checks = 0;
  int    failures = 0;
  int    n = 0;
  mode_t mode = MODE_RANDOM;
  logic [7:0]  const_color = 8'h00;
  logic [23:0] const_rgb = 24'h0;
  int    align_start = 0;
  string dut_tag [NDUT] = '{"full_l2", "small_l0", "small_l5"};

  int   hs_low, hs_fall;
  logic hs_prev;
  int   vs_low [NDUT];
  int   bl_high [NDUT];
  int   fs_cnt [NDUT];
  logic [NDUT-1:0] bl_prev;
  logic [NDUT-1:0] second_pending;

  always #5 clk = ~clk;

  vga_sync_gen #(
    .H_ACTIVE(HA[0]), .H_FP(HF[0]), .H_SYNC(HS[0]), .H_BP(HB[0]),
    .V_ACTIVE(VA[0]), .V_FP(VF[0]), .V_SYNC(VS[0]), .V_BP(VB[0]), .PIPE_LAT(LAT[0])
  ) u_full_l2 (
    .vga_clk(clk), .rst_n(rst_n), .pixel_color(pix[0]), .x(xo[0]), .y(yo[0]),
    .active(act[0]), .frame_start(fs[0]), .vga_hs(hs[0]), .vga_vs(vs[0]),
    .vga_blank_n(bl[0]), .vga_sync_n(sn[0]), .vga_r(ro[0]), .vga_g(go[0]), .vga_b(bo[0])
  );

  vga_sync_gen #(
    .H_ACTIVE(HA[1]), .H_FP(HF[1]), .H_SYNC(HS[1]), .H_BP(HB[1]),
    .V_ACTIVE(VA[1]), .V_FP(VF[1]), .V_SYNC(VS[1]), .V_BP(VB[1]), .PIPE_LAT(LAT[1])
  ) u_small_l0 (
    .vga_clk(clk), .rst_n(rst_n), .pixel_color(pix[1]), .x(xo[1]), .y(yo[1]),
    .active(act[1]), .frame_start(fs[1]), .vga_hs(hs[1]), .vga_vs(vs[1]),
    .vga_blank_n(bl[1]), .vga_sync_n(sn[1]), .vga_r(ro[1]), .vga_g(go[1]), .vga_b(bo[1])
  );

  vga_sync_gen #(
    .H_ACTIVE(HA[2]), .H_FP(HF[2]), .H_SYNC(HS[2]), .H_BP(HB[2]),
    .V_ACTIVE(VA[2]), .V_FP(VF[2]), .V_SYNC(VS[2]), .V_BP(VB[2]), .PIPE_LAT(LAT[2])
  ) u_small_l5 (
    .vga_clk(clk), .rst_n(rst_n), .pixel_color(pix[2]), .x(xo[2]), .y(yo[2]),
    .active(act[2]), .frame_start(fs[2]), .vga_hs(hs[2]), .vga_vs(vs[2]),
    .vga_blank_n(bl[2]), .vga_sync_n(sn[2]), .vga_r(ro[2]), .vga_g(go[2]), .vga_b(bo[2])
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s at n=%0d got=%h expected=%h", tag, n, got, want);
    end
  endtask

  function automatic int h_total(input int i);
    return HA[i] + HF[i] + HS[i] + HB[i];
  endfunction

  function automatic int v_total(input int i);
    return VA[i] + VF[i] + VS[i] + VB[i];
  endfunction

  function automatic int h_pos(input int i, input int cyc);
    return (cyc % (h_total(i) * v_total(i))) % h_total(i);
  endfunction

  // Colour levels are the nearest 8-bit value to an even spread of the 3- or 2-bit level.
  function automatic logic [23:0] expand_color(input logic [7:0] c);
    int r3, g3, b2, r8, g8, b8;
    r3 = int'(c[7:5]);
    g3 = int'(c[4:2]);
    b2 = int'(c[1:0]);
    r8 = (r3 * 255 + 3) / 7;
    g8 = (g3 * 255 + 3) / 7;
    b8 = b2 * 85;
    return {8'(r8), 8'(g8), 8'(b8)};
  endfunction

  // Pins during cycle n show the position from n-LAT-1 cycles and the colour driven in cycle n-1.
  function automatic logic [63:0] expect_out(input int i, input int cyc, input logic [7:0] col);
    int ht, vt, m, h, v, k, hk, vk;
    logic a, f, hse, vse, ble;
    logic [23:0] rgb;
    ht = h_total(i);
    vt = v_total(i);
    m = cyc % (ht * vt);
    h = m % ht;
    v = m / ht;
    a = (h < HA[i]) && (v < VA[i]);
    f = (m == 0);
    hse = 1'b1;
    vse = 1'b1;
    ble = 1'b0;
    rgb = 24'h0;
    k = cyc - LAT[i] - 1;
    if (k >= 0) begin
      hk = (k % (ht * vt)) % ht;
      vk = (k % (ht * vt)) / ht;
      hse = !((hk >= HA[i] + HF[i]) && (hk < HA[i] + HF[i] + HS[i]));
      vse = !((vk >= VA[i] + VF[i]) && (vk < VA[i] + VF[i] + VS[i]));
      ble = (hk < HA[i]) && (vk < VA[i]);
      if (ble) rgb = expand_color(col);
    end
    return {14'd0, 10'(h), 10'(v), a, f, hse, vse, ble, 1'b0, rgb};
  endfunction

  function automatic logic [63:0] observed(input int i);
    return {14'd0, xo[i], yo[i], act[i], fs[i], hs[i], vs[i], bl[i], sn[i], ro[i], go[i], bo[i]};
  endfunction

  task automatic applyStimulus();
    for (int i = 0; i < NDUT; i++) begin
      case (mode)
        MODE_CONST: pix[i] = const_color;
        MODE_ALIGN: pix[i] = (n >= LAT[i]) ? 8'(h_pos(i, n - LAT[i])) : 8'h00;
        default:    pix[i] = 8'($urandom);
      endcase
    end
  endtask

  task automatic clear_measure();
    hs_low = 0;
    hs_fall = -1;
    hs_prev = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      vs_low[i] = 0;
      bl_high[i] = 0;
      fs_cnt[i] = 0;
    end
  endtask

  task automatic run_cycles(input int count);
    for (int c = 0; c < count; c++) begin
      @(posedge clk);
      #1;
      if (rst_n) n++;
      for (int i = 0; i < NDUT; i++) begin
        checkOutput(dut_tag[i], observed(i), expect_out(i, n, pix[i]));
        if (rst_n && n >= 1 && n <= 2 * h_total(i) * v_total(i) && i != 0) begin
          if (!vs[i]) vs_low[i]++;
          if (bl[i]) bl_high[i]++;
          if (fs[i]) fs_cnt[i]++;
        end
        if (mode == MODE_ALIGN && rst_n && n >= align_start + LAT[i] + 2) begin
          if (bl[i] && !bl_prev[i]) begin
            checkOutput({"align_first_", dut_tag[i]}, {40'd0, ro[i], go[i], bo[i]}, 64'h0);
            second_pending[i] = 1'b1;
          end else if (second_pending[i]) begin
            checkOutput({"align_second_", dut_tag[i]}, {40'd0, ro[i], go[i], bo[i]}, 64'h55);
            second_pending[i] = 1'b0;
          end
        end
        bl_prev[i] = bl[i];
      end
      if (rst_n && n < 800) begin
        if (!hs[0]) hs_low++;
        if (hs_prev && !hs[0]) hs_fall = n;
      end
      hs_prev = hs[0];
      if (mode == MODE_CONST && rst_n && pix[0] == const_color) begin
        if (bl[0]) checkOutput("rgb_visible", {40'd0, ro[0], go[0], bo[0]}, {40'd0, const_rgb});
        else       checkOutput("rgb_blank", {40'd0, ro[0], go[0], bo[0]}, 64'h0);
      end
      applyStimulus();
    end
  endtask

  task automatic check_windows(input string phase);
    checkOutput({phase, "_hs_low_len"}, 64'(hs_low), 64'(HS[0]));
    checkOutput({phase, "_hs_fall"}, 64'(hs_fall), 64'(HA[0] + HF[0] + LAT[0] + 1));
    for (int i = 1; i < NDUT; i++) begin
      checkOutput({phase, "_vs_low_", dut_tag[i]}, 64'(vs_low[i]), 64'(2 * VS[i] * h_total(i)));
      checkOutput({phase, "_blank_", dut_tag[i]}, 64'(bl_high[i]), 64'(2 * HA[i] * VA[i]));
      checkOutput({phase, "_frames_", dut_tag[i]}, 64'(fs_cnt[i]), 64'd2);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bl_prev = '0;
    second_pending = '0;
    for (int i = 0; i < NDUT; i++) pix[i] = 8'h00;
    clear_measure();
    run_cycles(5);
    checkOutput("reset_pins", observed(0), {14'd0, 10'd0, 10'd0, 6'b111100, 24'h0});

    rst_n = 1'b1;
    run_cycles(2400);
    check_windows("first");

    mode = MODE_CONST;
    const_color = 8'b111_000_11;
    const_rgb = 24'hFF00FF;
    run_cycles(800);
    const_color = 8'b010_101_10;
    const_rgb = 24'h49B6AA;
    run_cycles(800);

    mode = MODE_ALIGN;
    align_start = n;
    run_cycles(1600);

    mode = MODE_RANDOM;
    for (int guard = 0; guard < 1000 && (n % 800) != 300; guard++) run_cycles(1);
    checkOutput("midreset_x_before", {54'd0, xo[0]}, 64'd300);
    rst_n = 1'b0;
    #1;
    n = 0;
    for (int i = 0; i < NDUT; i++)
      checkOutput({"midreset_", dut_tag[i]}, observed(i), expect_out(i, 0, pix[i]));
    run_cycles(3);
    clear_measure();
    rst_n = 1'b1;
    run_cycles(1100);
    check_windows("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

endmodule
